seq_bin2bcd: RTL and testbench
==============================

Name: seq_bin2bcd

Overview:
- Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Successor to the fixed 8-bit combinational converter: any input width, any digit count, start/busy/done handshake.
- Adds leading-zero blanking flags for the score and length displays.
- Sits between the game-state counters and the 7-segment/VGA digit renderers.

Parameters:
- BIN_W, 8, width of binary input (legal range 1..32).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1. Simulation check fires at time 0 if violated.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a conversion of BIN; honoured only when BUSY=0.
- BIN  input  BIN_W  binary value; sampled only on the accepting edge.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse; BCD/BLANK updated in the same cycle.
- BCD  output  4*DIGITS  packed result; digit i at bits [4i+3:4i], digit 0 = ones.
- BLANK  output  DIGITS  BLANK[i]=1 when digit i and all higher digits are zero, for i≥1. BLANK[0] is always 0.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, BUSY=0, DONE=0, BCD=0, BLANK={DIGITS-1 ones, 0}, internal shift register and bit counter cleared. Reset overrides everything, including mid-conversion; the partial result is discarded.
- States:
  - IDLE: BUSY=0. On an edge with START=1: load the bit register with BIN, clear the digit register, set counter=BIN_W, go to SHIFT.
  - SHIFT: BUSY=1. Each edge performs one iteration:
    - For every digit ≥5, add 3 (4-bit wrap impossible by construction).
    - Shift {digits, bits} left by 1; the MSB of the bit register enters digit 0 LSB.
    - Decrement the counter.
    - On the edge where the counter goes 1→0: register the final digits into BCD, compute BLANK from them, set DONE=1, BUSY=0, go to IDLE.
- DONE is high for exactly one cycle, otherwise 0.
- Latency: START sampled at edge 0. BUSY is high for exactly BIN_W cycles (edges 1..BIN_W). DONE and the new BCD are visible after edge BIN_W.
- Throughput: START high in the DONE cycle is accepted (state already IDLE), giving one conversion per BIN_W+1 cycles back-to-back.
- START while BUSY=1 is ignored, not queued. BIN changes during BUSY have no effect.
- BCD and BLANK hold the last completed result until the next DONE; they are never exposed mid-conversion.
- Unused upper digits (when DIGITS exceeds the minimum) read 0 and are blanked.
- Counter width: $clog2(BIN_W+1).

Decomposition:
- Shared include bcd_defs.vh:
  - state encodings (IDLE, SHIFT)
  - BCD_DIGIT_W=4
  - ADJ_THRESHOLD=5, ADJ_VALUE=3
- Sub-module bcd_digit_adj: purely combinational, 4-bit in / 4-bit out, adds 3 when input ≥5. Instantiated DIGITS times via generate.
- Blanking logic: a generate loop in the top module (BLANK[i] = BLANK[i+1] & (digit i == 0), top digit from its own zero test), no separate module.

Test Plan:
1. Default params, BIN=255, START 1 cycle → BUSY high exactly 8 cycles; DONE after edge 8; BCD=12'h255, BLANK=3'b000.
2. BIN=0 then BIN=7 back-to-back (START held high in the first DONE cycle) → first DONE: BCD=12'h000, BLANK=3'b110. Second DONE exactly 9 cycles later: BCD=12'h007, BLANK=3'b110.
3. BIN=42 accepted; pulse START with BIN=200 on cycle 3 of BUSY → ignored; single DONE with BCD=12'h042, BLANK=3'b100; no second DONE.
4. BIN_W=14, DIGITS=5, BIN=9999 → BUSY 14 cycles; BCD=20'h09999, BLANK=5'b10000. Then BIN=16383 → BCD=20'h16383, BLANK=5'b00000.
5. BIN=99 accepted; assert RST on cycle 4 of BUSY → next cycle BUSY=0, DONE=0, BCD=0, BLANK=3'b110. No DONE follows until a new START.
6. Exhaustive sweep, BIN_W=8, BIN 0..255, each result compared with the decimal reference model → all match; DONE count = 256.

Source files
------------

// File: rtl/seq_bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package seq_bin2bcd_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned ADJ_THRESHOLD = 5;
    localparam int unsigned ADJ_VALUE     = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // 10^n in 64 bits, used for the elaboration-time range check.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_bin2bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module seq_bin2bcd_digit_adj
    import seq_bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit_c
);

    // Digits entering a shift are at most 9, so the sum never wraps.
    assign o_digit_c = (i_digit >= BCD_DIGIT_W'(ADJ_THRESHOLD))
                     ? i_digit + BCD_DIGIT_W'(ADJ_VALUE)
                     : i_digit;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with
// start/busy/done handshake and leading-zero blanking flags.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [BIN_W-1:0]              i_bin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd,
    output logic [DIGITS-1:0]             o_blank
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    // Digit 0 is never blanked; also the reset value of the blank flags.
    localparam logic [DIGITS-1:0] BLANK_MASK = ~DIGITS'(1);

    // Digit count must cover the largest input value.
    if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_params
        $error("seq_bin2bcd: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    state_t             r_state, w_state_nxt;
    logic [BIN_W-1:0]   r_bits, w_bits_nxt;
    logic [BCD_W-1:0]   r_digits, w_digits_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [DIGITS-1:0]  r_blank, w_blank_nxt;

    logic [BCD_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat;
    logic [BCD_W-1:0]   w_shift_digits;
    logic [BIN_W-1:0]   w_shift_bits;
    logic [DIGITS-1:0]  w_zero;
    logic [DIGITS-1:0]  w_blank_calc;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        seq_bin2bcd_digit_adj u_adj (
            .i_digit   (r_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit_c (w_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift {digits, bits} left by one; bit MSB enters digit 0 LSB.
    assign w_cat          = {w_adj, r_bits} << 1;
    assign w_shift_digits = w_cat[CAT_W-1:BIN_W];
    assign w_shift_bits   = w_cat[BIN_W-1:0];

    // Blank flag for digit i: it and every higher digit are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        assign w_zero[i]       = (w_shift_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(0));
        assign w_blank_calc[i] = &w_zero[DIGITS-1:i];
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt  = r_state;
        w_bits_nxt   = r_bits;
        w_digits_nxt = r_digits;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_bcd_nxt    = r_bcd;
        w_blank_nxt  = r_blank;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_bits_nxt   = i_bin;
                    w_digits_nxt = '0;
                    w_cnt_nxt    = CNT_W'(BIN_W);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bits_nxt   = w_shift_bits;
                w_digits_nxt = w_shift_digits;
                w_cnt_nxt    = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_bcd_nxt   = w_shift_digits;
                    w_blank_nxt = w_blank_calc & BLANK_MASK;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_bits   <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
            r_blank  <= BLANK_MASK;
        end else begin
            r_state  <= w_state_nxt;
            r_bits   <= w_bits_nxt;
            r_digits <= w_digits_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_bcd    <= w_bcd_nxt;
            r_blank  <= w_blank_nxt;
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_bcd   = r_bcd;
    assign o_blank = r_blank;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd: default 8-bit/3-digit and 14-bit/5-digit instances.
module tb_seq_bin2bcd;

    logic        clk;
    logic        rst;
    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [11:0] bcd8;
    logic [2:0]  blank8;
    logic        start14;
    logic [13:0] bin14;
    logic        busy14;
    logic        done14;
    logic [19:0] bcd14;
    logic [4:0]  blank14;

    int checks = 0;
    int errors = 0;
    int dn8    = 0;

    seq_bin2bcd u_dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start8),
        .i_bin   (bin8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_bcd   (bcd8),
        .o_blank (blank8)
    );

    seq_bin2bcd #(.BIN_W(14), .DIGITS(5)) u_dut14 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start14),
        .i_bin   (bin14),
        .o_busy  (busy14),
        .o_done  (done14),
        .o_bcd   (bcd14),
        .o_blank (blank14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done8) dn8++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion on one instance and wait (bounded) for DONE.
    task automatic convert(input bit wide, input logic [13:0] bin,
                           output int busy_cnt, output int lat, output bit timed_out);
        if (wide) begin start14 = 1'b1; bin14 = bin; end
        else      begin start8  = 1'b1; bin8  = bin[7:0]; end
        tick();
        start8 = 1'b0; start14 = 1'b0;
        busy_cnt = 0; lat = 0; timed_out = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (wide ? busy14 : busy8) busy_cnt++;
            tick();
            lat++;
            if (wide ? done14 : done8) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start14 = 1'b0; bin8 = '0; bin14 = '0;
        tick(); tick();
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL reset_ctl8 busy=%b done=%b exp 0 0", busy8, done8); end
        checks++; if (bcd8 !== 12'h000 || blank8 !== 3'b110) begin errors++; $display("FAIL reset_out8 bcd=%h blank=%b exp 000 110", bcd8, blank8); end
        checks++; if (bcd14 !== 20'h00000 || blank14 !== 5'b11110 || busy14 !== 1'b0) begin errors++; $display("FAIL reset_out14 bcd=%h blank=%b busy=%b exp 00000 11110 0", bcd14, blank14, busy14); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bc, lat; bit to;
        convert(1'b0, 14'd255, bc, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout no DONE within bound"); end
        checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
        checks++; if (bcd8 !== 12'h255 || blank8 !== 3'b000) begin errors++; $display("FAIL basic_255 bcd=%h blank=%b exp 255 000", bcd8, blank8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy8); end
        tick();
        checks++; if (done8 !== 1'b0 || bcd8 !== 12'h255) begin errors++; $display("FAIL basic_pulse done=%b bcd=%h exp 0 255", done8, bcd8); end
    endtask

    task automatic test_back_to_back();
        int lat; bit seen;
        start8 = 1'b1; bin8 = 8'd0;
        tick();
        start8 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_timeout no DONE"); end
        checks++; if (bcd8 !== 12'h000 || blank8 !== 3'b110) begin errors++; $display("FAIL b2b_zero bcd=%h blank=%b exp 000 110", bcd8, blank8); end
        start8 = 1'b1; bin8 = 8'd7;
        tick();
        start8 = 1'b0;
        lat = 1; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            lat++;
            if (done8) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || lat != 9) begin errors++; $display("FAIL b2b_spacing got %0d (seen=%b) exp 9", lat, seen); end
        checks++; if (bcd8 !== 12'h007 || blank8 !== 3'b110) begin errors++; $display("FAIL b2b_seven bcd=%h blank=%b exp 007 110", bcd8, blank8); end
        tick();
    endtask

    task automatic test_ignore_start();
        int d0; logic [11:0] cap_bcd; logic [2:0] cap_blank;
        cap_bcd = '1; cap_blank = '1;
        d0 = dn8;
        start8 = 1'b1; bin8 = 8'd42;
        tick();
        start8 = 1'b0;
        tick(); tick();
        start8 = 1'b1; bin8 = 8'd200;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done8 && cap_bcd === 12'hfff) begin cap_bcd = bcd8; cap_blank = blank8; end
            tick();
        end
        checks++; if (cap_bcd !== 12'h042 || cap_blank !== 3'b100) begin errors++; $display("FAIL ignore_result bcd=%h blank=%b exp 042 100", cap_bcd, cap_blank); end
        checks++; if (dn8 - d0 != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", dn8 - d0); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_idle busy=%b exp 0", busy8); end
    endtask

    task automatic test_wide();
        int bc, lat; bit to;
        convert(1'b1, 14'd9999, bc, lat, to);
        checks++; if (to !== 1'b0 || bc != 14 || lat != 14) begin errors++; $display("FAIL wide_timing busy=%0d lat=%0d to=%b exp 14 14 0", bc, lat, to); end
        checks++; if (bcd14 !== 20'h09999 || blank14 !== 5'b10000) begin errors++; $display("FAIL wide_9999 bcd=%h blank=%b exp 09999 10000", bcd14, blank14); end
        convert(1'b1, 14'd16383, bc, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL wide_timeout no DONE"); end
        checks++; if (bcd14 !== 20'h16383 || blank14 !== 5'b00000) begin errors++; $display("FAIL wide_16383 bcd=%h blank=%b exp 16383 00000", bcd14, blank14); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        start8 = 1'b1; bin8 = 8'd99;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL midrst_ctl busy=%b done=%b exp 0 0", busy8, done8); end
        checks++; if (bcd8 !== 12'h000 || blank8 !== 3'b110) begin errors++; $display("FAIL midrst_out bcd=%h blank=%b exp 000 110", bcd8, blank8); end
        d0 = dn8;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (dn8 != d0 || busy8 !== 1'b0) begin errors++; $display("FAIL midrst_no_done dones=%0d busy=%b exp 0 0", dn8 - d0, busy8); end
    endtask

    task automatic test_sweep();
        int bc, lat, d0; bit to;
        logic [11:0] exp_bcd; logic [2:0] exp_blank;
        d0 = dn8;
        for (int v = 0; v < 256; v++) begin
            convert(1'b0, 14'(v), bc, lat, to);
            exp_bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            exp_blank = {(v < 100), (v < 10), 1'b0};
            checks++; if (to || bcd8 !== exp_bcd || blank8 !== exp_blank) begin
                errors++; $display("FAIL sweep_%0d bcd=%h blank=%b to=%b exp %h %b", v, bcd8, blank8, to, exp_bcd, exp_blank);
            end
        end
        tick();
        checks++; if (dn8 - d0 != 256) begin errors++; $display("FAIL sweep_done_count got %0d exp 256", dn8 - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_wide();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
